// File: rtl/vga_scanout_pkg.sv
// Shared types, default VGA timing and palette for the scanout block.
// Timing and geometry defaults describe 640x480@60 with a 320x240 framebuffer.
package vga_scanout_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } position_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } scan_state_t;

  localparam int DEF_FB_W     = 320;
  localparam int DEF_FB_H     = 240;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Linear framebuffer address; with fb_w=320 this is (y<<8)+(y<<6)+x.
  function automatic logic [16:0] fb_addr(input logic [9:0] x, input logic [8:0] y,
                                          input int fb_w);
    fb_addr = (17'(y) * 17'(fb_w)) + 17'(x);
  endfunction

  function automatic logic [11:0] palette_rgb(input logic [2:0] code);
    case (code)
      3'd0:    palette_rgb = 12'h000;
      3'd1:    palette_rgb = 12'hFFF;
      3'd2:    palette_rgb = 12'h888;
      3'd3:    palette_rgb = 12'hF00;
      3'd4:    palette_rgb = 12'h0F0;
      3'd5:    palette_rgb = 12'h00F;
      3'd6:    palette_rgb = 12'hFF0;
      3'd7:    palette_rgb = 12'h0FF;
      default: palette_rgb = 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Pixel write port between the draw stage (master) and the scanout block (slave).
interface vga_scanout_if;
  import vga_scanout_pkg::*;

  position_t  write_pos;
  logic [2:0] write_data;
  logic       write_en;
  logic       fb_ready;

  modport master (output write_pos, output write_data, output write_en, input fb_ready);
  modport slave  (input write_pos, input write_data, input write_en, output fb_ready);

endinterface

// File: rtl/vga_scanout_timing.sv
// Free-running h/v counters with sync and active-area decode.
module vga_timing
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hsync,
  output logic       vsync
);

  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;

  // Pixel and line counters; v advances on every h wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Active area and active-low sync decode
  always_comb begin
    active = (h_cnt_r < H_ACT_L) && (v_cnt_r < V_ACT_L);
    hsync  = !((h_cnt_r >= HS_BEG) && (h_cnt_r <= HS_END));
    vsync  = !((v_cnt_r >= VS_BEG) && (v_cnt_r <= VS_END));
  end

  assign h_cnt = h_cnt_r;
  assign v_cnt = v_cnt_r;

endmodule

// File: rtl/vga_scanout.sv
// Colour-index framebuffer with post-reset clear and a 3-stage VGA scanout
// pipeline that doubles each stored pixel horizontally and vertically.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int FB_W     = DEF_FB_W,
  parameter int FB_H     = DEF_FB_H,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic         clk,
  input  logic         reset,
  vga_scanout_if.slave wr,
  output logic         hsync,
  output logic         vsync,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         frame_start
);

  localparam int          FB_DEPTH  = FB_W * FB_H;
  localparam logic [16:0] LAST_ADDR = 17'(FB_DEPTH - 1);
  localparam logic [9:0]  FB_W_L    = 10'(FB_W);
  localparam logic [8:0]  FB_H_L    = 9'(FB_H);

  scan_state_t state_r, state_s;
  logic [16:0] clr_addr_r;
  logic        fb_ready_r;
  logic        we_s;
  logic [16:0] waddr_s;
  logic [2:0]  wdata_s;

  logic [9:0]  h_cnt_s, v_cnt_s;
  logic        active_s, hsync_s, vsync_s;

  logic [16:0] s1_addr_r;
  logic        s1_active_r, s1_hsync_r, s1_vsync_r, s1_first_r;
  logic        s2_active_r, s2_hsync_r, s2_vsync_r, s2_first_r;
  logic [2:0]  rd_code_r;
  logic [11:0] rgb_s;

  logic [2:0]  fb_mem [FB_DEPTH];

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .h_cnt  (h_cnt_s),
    .v_cnt  (v_cnt_s),
    .active (active_s),
    .hsync  (hsync_s),
    .vsync  (vsync_s)
  );

  // Clear/run state, clear address and ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      clr_addr_r <= 17'd0;
      fb_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      fb_ready_r <= (state_s == ST_RUN);
      if (state_r == ST_CLEAR) begin
        clr_addr_r <= clr_addr_r + 17'd1;
      end
    end
  end

  // Next state and RAM write-port source: clear engine, then the external port
  always_comb begin
    state_s = state_r;
    we_s    = 1'b0;
    waddr_s = 17'd0;
    wdata_s = 3'd0;
    case (state_r)
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = clr_addr_r;
        if (clr_addr_r == LAST_ADDR) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (wr.write_en && (wr.write_pos.x < FB_W_L) && (wr.write_pos.y < FB_H_L)) begin
          we_s    = 1'b1;
          waddr_s = fb_addr(wr.write_pos.x, wr.write_pos.y, FB_W);
          wdata_s = wr.write_data;
        end else begin
          we_s    = 1'b0;
        end
      end
      default: state_s = ST_CLEAR;
    endcase
  end

  assign wr.fb_ready = fb_ready_r;

  // Framebuffer write port
  always_ff @(posedge clk) begin
    if (we_s) begin
      fb_mem[waddr_s] <= wdata_s;
    end
  end

  // Framebuffer read port; same-edge writes are not seen (read-first)
  always_ff @(posedge clk) begin
    rd_code_r <= fb_mem[s1_addr_r];
  end

  // S1: read address plus delayed qualifiers; pixels read before RUN are blanked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_addr_r   <= 17'd0;
      s1_active_r <= 1'b0;
      s1_hsync_r  <= 1'b1;
      s1_vsync_r  <= 1'b1;
      s1_first_r  <= 1'b0;
    end else begin
      s1_addr_r   <= fb_addr({1'b0, h_cnt_s[9:1]}, v_cnt_s[9:1], FB_W);
      s1_active_r <= active_s && (state_r == ST_RUN);
      s1_hsync_r  <= hsync_s;
      s1_vsync_r  <= vsync_s;
      s1_first_r  <= (h_cnt_s == 10'd0) && (v_cnt_s == 10'd0);
    end
  end

  // S2: qualifiers follow the RAM read stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_active_r <= 1'b0;
      s2_hsync_r  <= 1'b1;
      s2_vsync_r  <= 1'b1;
      s2_first_r  <= 1'b0;
    end else begin
      s2_active_r <= s1_active_r;
      s2_hsync_r  <= s1_hsync_r;
      s2_vsync_r  <= s1_vsync_r;
      s2_first_r  <= s1_first_r;
    end
  end

  assign rgb_s = palette_rgb(rd_code_r);

  // S3: palette lookup and registered pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= 4'd0;
      vga_g       <= 4'd0;
      vga_b       <= 4'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= s2_active_r ? rgb_s[11:8] : 4'd0;
      vga_g       <= s2_active_r ? rgb_s[7:4]  : 4'd0;
      vga_b       <= s2_active_r ? rgb_s[3:0]  : 4'd0;
      hsync       <= s2_hsync_r;
      vsync       <= s2_vsync_r;
      frame_start <= s2_first_r;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised bench for vga_scanout on a reduced screen geometry, checked
// cycle by cycle against a frame-level reference model.
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  localparam int FB_W = 16, FB_H = 12;
  localparam int HA = 32, HFP = 4, HS = 6, HB = 6;
  localparam int VA = 24, VFP = 2, VS = 2, VB = 4;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;
  localparam int CLR = FB_W * FB_H;
  localparam int PAL [8] = '{'h000, 'hFFF, 'h888, 'hF00, 'h0F0, 'h00F, 'hFF0, 'h0FF};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync, vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_scanout_if wr ();

  vga_scanout #(
    .FB_W(FB_W), .FB_H(FB_H),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  int   cyc;
  int   mem [CLR], prev [CLR], wedge [CLR];
  int   hs_fall, vs_fall;
  logic hs_prev, vs_prev;
  int   fbase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Screen counter k is visible on the pins 3 clocks later; the RAM sample for
  // k is taken at edge k+2, so it holds every write committed up to edge k+1.
  task automatic check_outputs();
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_fs;
    int          k, h, v, a, code;
    e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    if (cyc >= 3) begin
      k = cyc - 3;
      h = k % HT;
      v = (k / HT) % VT;
      e_hs = !(h >= HA + HFP && h < HA + HFP + HS);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VS);
      e_fs = (h == 0 && v == 0);
      if (h < HA && v < VA && k >= CLR) begin
        a = (v / 2) * FB_W + h / 2;
        code = (wedge[a] > k + 1) ? prev[a] : mem[a];
        e_rgb = 12'(PAL[code]);
      end
    end
    check("rgb", {vga_r, vga_g, vga_b}, 32'(e_rgb));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("fb_ready", 32'(wr.fb_ready), 32'(cyc >= CLR));
    if (hs_prev && !hsync) begin
      if (hs_fall >= 0) check("hs_period", 32'(cyc - hs_fall), 32'(HT));
      hs_fall = cyc;
    end
    if (!hs_prev && hsync && hs_fall >= 0) check("hs_low", 32'(cyc - hs_fall), 32'(HS));
    if (vs_prev && !vsync) begin
      if (vs_fall >= 0) check("vs_period", 32'(cyc - vs_fall), 32'(FT));
      vs_fall = cyc;
    end
    if (!vs_prev && vsync && vs_fall >= 0) check("vs_low", 32'(cyc - vs_fall), 32'(VS * HT));
    hs_prev = hsync;
    vs_prev = vsync;
  endtask

  task automatic step(input logic en, input int x, input int y, input int code);
    int a;
    wr.write_en = en;
    wr.write_pos.x = 10'(x);
    wr.write_pos.y = 9'(y);
    wr.write_data = 3'(code);
    @(posedge clk);
    if (en && x < FB_W && y < FB_H && cyc + 1 > CLR) begin
      a = y * FB_W + x;
      prev[a] = mem[a];
      mem[a] = code;
      wedge[a] = cyc + 1;
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  // Write strobe stays high but the position is off-screen, so nothing lands
  task automatic idle_step();
    step(1'b1, FB_W, $urandom_range(0, FB_H - 1), $urandom_range(0, 7));
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 4 * FT) begin
      idle_step();
      guard++;
    end
    check("run_to", 32'(cyc), 32'(target));
  endtask

  task automatic do_reset();
    wr.write_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_ready", 32'(wr.fb_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_hsync", 32'(hsync), 32'd1);
    check("rst_hold_rgb", {vga_r, vga_g, vga_b}, 32'd0);
    #2;
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < CLR; i++) begin
      mem[i] = 0; prev[i] = 0; wedge[i] = -100;
    end
    hs_fall = -1; vs_fall = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  initial begin
    int n;
    wr.write_pos = '0;
    wr.write_data = 3'd0;
    wr.write_en = 1'b0;
    #1;
    do_reset();
    for (int i = 0; i < 100; i++) idle_step();
    do_reset();

    n = 0;
    while (!wr.fb_ready && n < 2 * CLR) begin
      idle_step();
      n++;
    end
    check("clear_cycles", 32'(n), 32'(CLR));

    // Random writes in vertical blanking of frame 0
    run_to(VA * HT - 1);
    while (((cyc + 1) / HT) % VT < VT - 1)
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, FB_W + 2),
           $urandom_range(0, FB_H + 2), $urandom_range(0, 7));

    step(1'b1, 5, 3, 3);
    step(1'b1, 4, 3, 0);
    step(1'b1, 6, 3, 0);
    step(1'b1, FB_W, 0, 1);
    step(1'b1, 0, FB_H, 1);
    step(1'b1, 0, 0, 2);

    // Collision: commit to address 0 on the same edge its first read happens
    fbase = (cyc / FT + 1) * FT;
    run_to(fbase + 1);
    step(1'b1, 0, 0, 7);
    idle_step();
    check("pix00_old", {vga_r, vga_g, vga_b}, 32'h888);
    check("pix00_fs", 32'(frame_start), 32'd1);

    run_to(fbase + 3 + 6 * HT + 9);
    check("pix9_6", {vga_r, vga_g, vga_b}, 32'h000);
    idle_step();
    check("pix10_6", {vga_r, vga_g, vga_b}, 32'hF00);
    run_to(fbase + 3 + 6 * HT + 12);
    check("pix12_6", {vga_r, vga_g, vga_b}, 32'h000);
    run_to(fbase + 3 + 7 * HT + 11);
    check("pix11_7", {vga_r, vga_g, vga_b}, 32'hF00);

    run_to(fbase + FT + 3);
    check("pix00_new", {vga_r, vga_g, vga_b}, 32'h0FF);
    check("pix00_new_fs", 32'(frame_start), 32'd1);
    check("ready_kept", 32'(wr.fb_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the board/cursor draw stage. Accepts one pixel write per clock (position plus 3-bit colour code) into a 320x240 colour-index framebuffer.
- Concurrently scans the framebuffer out as 640x480@60 VGA, replicating each stored pixel 2x2.
- Palette lookup turns colour codes into 12-bit RGB.
- After reset, runs a clear sequence that fills the framebuffer with code 0 before accepting writes.

Parameters:
- FB_W, 320, framebuffer width in stored pixels
- FB_H, 240, framebuffer height in stored pixels
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clk cycles (total 800)
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal; all logic on posedge
- reset  in  1  asynchronous, active-high
- write_pos  in  position  framebuffer coordinate of the pixel being written (x, y fields)
- write_data  in  3  colour code to store
- write_en  in  1  write strobe; the write stage drives it high continuously
- fb_ready  out  1  high once the post-reset clear has finished
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- vga_r/vga_g/vga_b  out  4 each  pixel colour; zero outside active area
- frame_start  out  1  one-cycle pulse aligned with the first active pixel output of each frame

Behaviour:
- Reset (async, active-high):
  - h_cnt=0, v_cnt=0, clear address=0, state=CLEAR.
  - hsync=1, vsync=1, rgb=0, frame_start=0, fb_ready=0.
  - All pipeline valid/sync delay bits cleared to their inactive values.
  - Framebuffer RAM contents are not reset.
- State machine:
  - CLEAR: writes code 0 to address clr_addr each cycle, clr_addr++. External writes are ignored. RGB is forced to 0, but sync timing keeps running. When clr_addr == FB_W*FB_H-1 is written, go to RUN. Duration is exactly 76800 cycles.
  - RUN: fb_ready=1; external writes accepted. RUN is left only through reset.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from address 0.
- Write port (RUN):
  - Accepted when write_en=1, x<FB_W and y<FB_H. Out-of-range positions are silently dropped.
  - addr = y*FB_W + x, computed as (y<<8)+(y<<6)+x, 17-bit unsigned.
  - The write is committed on the same posedge.
- Timing counters:
  - h_cnt counts 0..799 and wraps to 0; v_cnt increments on each h_cnt wrap and counts 0..524, wrapping to 0.
  - active = h_cnt<640 && v_cnt<480.
  - hsync low for h_cnt in [656,751]; vsync low for v_cnt in [490,491].
- Read pipeline (fixed 3-cycle latency from counter value to pins):
  - S1: registers read address (v_cnt>>1)*FB_W + (h_cnt>>1), plus delayed active/hsync/vsync.
  - S2: synchronous RAM read, registered.
  - S3: palette lookup registered onto vga_r/g/b. hsync/vsync/frame_start are delayed to match.
  - Outputs for counter (h,v) appear exactly 3 clocks later. Inactive pixels output 0.
- Write/read collision on the same address in the same cycle: the read returns the old data (read-first). The new value becomes visible on the next frame.
- frame_start is asserted when S3 holds (h=0, v=0).

Decomposition:
- screen package: position typedef (x 10 bits, y 9 bits), VGA timing constants, and the 8-entry palette. The palette is a 12-bit RGB array:
  - 0 black 000, 1 white FFF, 2 grey 888, 3 red F00
  - 4 green 0F0, 5 blue 00F, 6 yellow FF0, 7 cyan 0FF
- Sub-module vga_timing: the h/v counters plus sync/active generation, instantiated once.
- The framebuffer is inferred as simple dual-port RAM inside vga_scanout.

Test Plan:
- Reset, then count cycles until fb_ready rises -> exactly 76800 cycles. Every read during this period returns rgb=000.
- Hold reset low and measure hsync and vsync -> hsync period 800 clk with 96-cycle low pulse; vsync period 420000 clk with 1600-cycle low pulse.
- After fb_ready, write (x=5, y=3, code 3) -> on the next frame, screen pixels x=10..11, y=6..7 output F00. Neighbours x=9 and x=12 output 000.
- Write (x=320, y=0, code 1) and (x=0, y=240, code 1) -> no change anywhere on screen; fb_ready stays 1.
- Assert reset at clr_addr=40000, release -> fb_ready takes a full 76800 cycles again; hsync=1 and rgb=0 while reset is asserted.
- Write code 7 to (0,0) in the cycle S1 reads address 0 -> the current frame shows the old value at pixel (0,0). The next frame shows 0FF, and frame_start pulses with that pixel.
